// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Per-operand priority comparator (EX > MEM > WB); combinational, no backpressure.
// Also flags a load-use match against the EX stage.
module hazard_fwd_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_enable,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_enable,
    output fwd_sel_t         sel,
    output logic             lu
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = use_src && ex_rf_enable  && (ex_rd  == src);
    assign mem_hit = use_src && mem_rf_enable && (mem_rd == src);
    assign wb_hit  = use_src && wb_rf_enable  && (wb_rd  == src);
    assign lu      = ex_hit && ex_load;

    // A load in EX has no data yet, so selection falls through to older stages.
    always_comb begin
        sel = FWD_RF;
        if (ex_hit && !ex_load) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline; outputs are zero-latency combinational.
// Stalls freeze PC and IF/ID and bubble the control unit; HAZ_FORWARD_EN enables operand forwarding.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_use_rn,
    input  logic             ID_use_rm,
    input  logic             ID_use_rd,
    input  logic             ID_B_instr,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] EX_Rd,
    input  logic             EX_RF_enable,
    input  logic             EX_load_instr,
    input  logic [REG_W-1:0] MEM_Rd,
    input  logic             MEM_RF_enable,
    input  logic [REG_W-1:0] WB_Rd,
    input  logic             WB_RF_enable,
    output logic             PC_LE,
    output logic             IFID_LE,
    output logic             IFID_flush,
    output logic             CU_mux_sel,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       fwd_C,
    output logic [CNT_W-1:0] stall_count
);

    localparam int BW = $clog2(LOAD_BUBBLES + 1);

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bcnt;
    logic [BW-1:0]   bcnt_nxt;
    fwd_sel_t        sel_a;
    fwd_sel_t        sel_b;
    fwd_sel_t        sel_c;
    logic            lu_a;
    logic            lu_b;
    logic            lu_c;
    logic            lu_any;
    logic            hazard;
    logic            stall;

    hazard_fwd_sel u_sel_a (
        .src           (ID_Rn),
        .use_src       (ID_use_rn),
        .ex_rd         (EX_Rd),
        .ex_rf_enable  (EX_RF_enable),
        .ex_load       (EX_load_instr),
        .mem_rd        (MEM_Rd),
        .mem_rf_enable (MEM_RF_enable),
        .wb_rd         (WB_Rd),
        .wb_rf_enable  (WB_RF_enable),
        .sel           (sel_a),
        .lu            (lu_a)
    );

    hazard_fwd_sel u_sel_b (
        .src           (ID_Rm),
        .use_src       (ID_use_rm),
        .ex_rd         (EX_Rd),
        .ex_rf_enable  (EX_RF_enable),
        .ex_load       (EX_load_instr),
        .mem_rd        (MEM_Rd),
        .mem_rf_enable (MEM_RF_enable),
        .wb_rd         (WB_Rd),
        .wb_rf_enable  (WB_RF_enable),
        .sel           (sel_b),
        .lu            (lu_b)
    );

    hazard_fwd_sel u_sel_c (
        .src           (ID_Rd),
        .use_src       (ID_use_rd),
        .ex_rd         (EX_Rd),
        .ex_rf_enable  (EX_RF_enable),
        .ex_load       (EX_load_instr),
        .mem_rd        (MEM_Rd),
        .mem_rf_enable (MEM_RF_enable),
        .wb_rd         (WB_Rd),
        .wb_rf_enable  (WB_RF_enable),
        .sel           (sel_c),
        .lu            (lu_c)
    );

    assign lu_any = lu_a || lu_b || lu_c;

`ifdef HAZ_FORWARD_EN
    assign hazard = lu_any;
    assign fwd_A  = CLR ? FWD_RF : sel_a;
    assign fwd_B  = CLR ? FWD_RF : sel_b;
    assign fwd_C  = CLR ? FWD_RF : sel_c;
`else
    // Without forwarding, any pending producer of a used source is a hazard.
    assign hazard = lu_any || (sel_a != FWD_RF) || (sel_b != FWD_RF) || (sel_c != FWD_RF);
    assign fwd_A  = FWD_RF;
    assign fwd_B  = FWD_RF;
    assign fwd_C  = FWD_RF;
`endif

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        stall     = 1'b0;
        case (state)
            ST_RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    if (lu_any && (LOAD_BUBBLES > 1)) begin
                        state_nxt = ST_BUBBLE;
                        bcnt_nxt  = BW'(LOAD_BUBBLES - 1);
                    end
                end
            end
            ST_BUBBLE: begin
                stall    = 1'b1;
                bcnt_nxt = bcnt - BW'(1);
                if (bcnt == BW'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                bcnt_nxt  = '0;
            end
        endcase
        if (CLR) begin
            stall = 1'b0;
        end
    end

    assign PC_LE      = !stall;
    assign IFID_LE    = !stall;
    assign CU_mux_sel = stall;
    assign IFID_flush = !CLR && !stall && (state == ST_RUN) && ID_B_instr && branch_taken;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= ST_RUN;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Saturating: holds at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
